pipeline_register: RTL and testbench
====================================

Name: pipeline_register

Overview:
- Single-stage valid/ready pipeline register that breaks the forward timing path between a producer and a consumer.
- Lossless: every accepted word is presented exactly once, in order.
- Optional skid-buffer mode also registers the ready path, so neither direction has a combinational path through the block.
- Sits between any two streaming stages of the datapath.

Parameters:
- DATA_WIDTH, 8, payload width in bits (>=1).
- REG_READY, 0. 0 = single-entry register with combinational in_ready. 1 = two-entry skid buffer with registered in_ready.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DATA_WIDTH  producer payload.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  DATA_WIDTH  payload to consumer.

Behaviour:
Interface and reset:
- One clock domain (clk); reset rst_n is asynchronous, active-low.
- Reset asserted: all entries empty immediately (no clock needed); out_valid=0; out_data=0; skid entry cleared.
- Reset state of in_ready: 1 in both modes (REG_READY=0 follows from empty; REG_READY=1 register resets to 1).
- Reset mid-transfer discards stored words; no handshake completes on the edge where rst_n is low.

Handshake:
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- out_valid and out_data are driven only from registers; no combinational in→out path.
- Once out_valid=1, out_valid and out_data stay stable until an output transfer; in_data changes have no effect.
- in_valid may fall without a transfer; the block never requires it to stay high.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N (one cycle), when the block was empty.

REG_READY=0 (single entry):
- in_ready = !out_valid | out_ready (combinational from out_ready).
- Empty + input transfer → full, out_data=in_data.
- Full + output transfer + input transfer → stays full, out_data replaced by the new word. This gives full throughput (1 word/cycle).
- Full + output transfer, no input → empty, out_valid=0; out_data holds its last value.
- Full + out_ready=0 → in_ready=0; hold state.

REG_READY=1 (skid buffer):
- States: EMPTY (0 words), ONE (main only), TWO (main+skid).
- in_ready is a flop, equal to (state != TWO).
- EMPTY, input transfer → ONE.
- ONE:
  - input only → TWO; the word goes to skid.
  - output only → EMPTY.
  - both → ONE; the new word goes to main.
- TWO: output transfer → ONE; skid moves to main; no input accepted.
- Sustained throughput: 1 word/cycle; ordering preserved.

Boundary conditions:
- Simultaneous input and output transfer in the full state never drops or duplicates a word.
- in_valid=1 while in_ready=0: no acceptance; the producer must hold the data.
- Arbitrary out_ready toggling must not lose words in either mode.
- Output is X-free after reset.

Test Plan:
1. Reset, then in_valid=1, in_data=0xAA, out_ready=1 for one edge, then in_valid=0 → in_ready=1 before the edge; after it out_valid=1, out_data=0xAA; next edge out_valid=0.
2. out_ready=0, in_valid=1, in_data=0xBB held 3 edges → out_valid=1, out_data=0xBB. in_ready=0 after 1 edge (REG_READY=0) or 2 edges (REG_READY=1). Then out_ready=1 → 0xBB delivered exactly once per accepted copy.
3. Streaming 0x01..0x10, in_valid=1 and out_ready=1 continuously → one word per cycle, in order, no gaps after the first-word latency.
4. Random out_ready (50%) and random in_valid, 1000 words through a scoreboard → no loss, duplication or reorder. Stability checks hold while out_valid & !out_ready.
5. Reset asserted asynchronously (mid-cycle) while full → out_valid=0 and out_data=0 immediately. After release, in_ready=1 and the next word 0xDD flows through normally.
6. Run all of the above with REG_READY=0 and REG_READY=1. Also check that in_ready never depends combinationally on out_ready when REG_READY=1.

Source files
------------

// File: rtl/pipeline_register.sv
// Single-stage valid/ready pipeline register; REG_READY=1 adds a skid entry so the
// ready path is registered as well as the forward path.
module pipeline_register #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REG_READY  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    if (REG_READY == 0) begin : g_single
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  in_xfer;

        // Accepting while the consumer drains the current word keeps full throughput.
        assign in_ready = !valid_q || out_ready;
        assign in_xfer  = in_valid && in_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (in_xfer) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
    end else begin : g_skid
        typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

        state_e                state_q, state_d;
        logic [DATA_WIDTH-1:0] main_q, main_d;
        logic [DATA_WIDTH-1:0] skid_q, skid_d;
        logic                  in_ready_q;
        logic                  out_valid_q;
        logic                  in_xfer;
        logic                  out_xfer;

        assign in_xfer  = in_valid && in_ready_q;
        assign out_xfer = out_valid_q && out_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        // Consumer stalled after we promised ready: park the word.
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= StEmpty;
                main_q      <= '0;
                skid_q      <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                main_q      <= main_d;
                skid_q      <= skid_d;
                in_ready_q  <= (state_d != StTwo);
                out_valid_q <= (state_d != StEmpty);
            end
        end

        assign in_ready  = in_ready_q;
        assign out_valid = out_valid_q;
        assign out_data  = main_q;
    end

endmodule

// File: tb/tb_pipeline_register.sv
// Bench for pipeline_register: both REG_READY modes against a queue-based model of the
// stored words.
module tb_pipeline_register;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    in_valid;
    logic [1:0]    in_ready;
    logic [1:0]    out_valid;
    logic [1:0]    out_ready;
    logic [DW-1:0] in_data  [2];
    logic [DW-1:0] out_data [2];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cur      = 0;
    logic [DW-1:0] mq[$];
    bit            popped;
    bit            accepted;
    logic [DW-1:0] popped_word;

    always #5 clk = ~clk;

    pipeline_register #(.DATA_WIDTH(DW), .REG_READY(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0])
    );

    pipeline_register #(.DATA_WIDTH(DW), .REG_READY(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1])
    );

    // Mode 0 can take a word if empty or draining now; mode 1 whenever below capacity 2.
    function automatic bit exp_in_ready();
        if (cur == 0) return (mq.size() == 0) || out_ready[cur];
        return mq.size() < 2;
    endfunction

    task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy);
        in_valid[cur]  = iv;
        in_data[cur]   = d;
        out_ready[cur] = ordy;
    endtask

    task automatic model_edge();
        bit            ir, iv, ov, ordy;
        logic [DW-1:0] d;
        ir   = exp_in_ready();
        iv   = in_valid[cur];
        ov   = mq.size() > 0;
        ordy = out_ready[cur];
        d    = in_data[cur];
        @(posedge clk);
        popped   = 1'b0;
        accepted = 1'b0;
        if (ov && ordy) begin
            popped_word = mq.pop_front();
            popped      = 1'b1;
        end
        if (iv && ir) begin
            mq.push_back(d);
            accepted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        in_valid  = '0;
        out_ready = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid[cur] !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid m=%0d got=%b exp=0", cur, out_valid[cur]);
        end
        n_checks++;
        if (out_data[cur] !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_data m=%0d got=%h exp=00", cur, out_data[cur]);
        end
        n_checks++;
        if (in_ready[cur] !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready m=%0d got=%b exp=1", cur, in_ready[cur]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        #1;
        n_checks++;
        if (in_ready[cur] !== 1'b1 || out_valid[cur] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset m=%0d got rdy=%b vld=%b exp rdy=1 vld=0",
                               cur, in_ready[cur], out_valid[cur]);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        drive(1'b1, 8'hAA, 1'b1);
        #1;
        n_checks++;
        if (in_ready[cur] !== 1'b1) begin
            n_fail++; $display("FAIL single_in_ready m=%0d got=%b exp=1", cur, in_ready[cur]);
        end
        model_edge();
        n_checks++;
        if (out_valid[cur] !== 1'b1 || out_data[cur] !== 8'hAA) begin
            n_fail++; $display("FAIL single_out m=%0d got vld=%b data=%h exp vld=1 data=aa",
                               cur, out_valid[cur], out_data[cur]);
        end
        drive(1'b0, 8'h00, 1'b1);
        model_edge();
        n_checks++;
        if (out_valid[cur] !== 1'b0) begin
            n_fail++; $display("FAIL single_drain m=%0d got=%b exp=0", cur, out_valid[cur]);
        end
    endtask

    task automatic test_backpressure();
        int delivered;
        bit exp_rdy;
        drive(1'b1, 8'hBB, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            model_edge();
            exp_rdy = (cur == 0) ? 1'b0 : (e < 2);
            n_checks++;
            if (out_valid[cur] !== 1'b1 || out_data[cur] !== 8'hBB) begin
                n_fail++; $display("FAIL bp_hold e=%0d m=%0d got vld=%b data=%h exp vld=1 data=bb",
                                   e, cur, out_valid[cur], out_data[cur]);
            end
            n_checks++;
            if (in_ready[cur] !== exp_rdy) begin
                n_fail++; $display("FAIL bp_in_ready e=%0d m=%0d got=%b exp=%b",
                                   e, cur, in_ready[cur], exp_rdy);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        delivered = 0;
        for (int e = 0; e < 4; e++) begin
            #1;
            if (out_valid[cur] === 1'b1 && out_data[cur] === 8'hBB) delivered++;
            model_edge();
        end
        n_checks++;
        if (delivered != cur + 1) begin
            n_fail++; $display("FAIL bp_delivered m=%0d got=%0d exp=%0d", cur, delivered, cur + 1);
        end
        n_checks++;
        if (out_valid[cur] !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty m=%0d got=%b exp=0", cur, out_valid[cur]);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] k8;
        for (int k = 1; k <= 16; k++) begin
            k8 = DW'(k);
            drive(1'b1, k8, 1'b1);
            #1;
            n_checks++;
            if (in_ready[cur] !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready k=%0d m=%0d got=%b exp=1", k, cur, in_ready[cur]);
            end
            if (k > 1) begin
                n_checks++;
                if (out_valid[cur] !== 1'b1 || out_data[cur] !== k8 - 8'd1) begin
                    n_fail++; $display("FAIL stream_out k=%0d m=%0d got vld=%b data=%h exp vld=1 data=%h",
                                       k, cur, out_valid[cur], out_data[cur], k8 - 8'd1);
                end
            end
            model_edge();
        end
        drive(1'b0, 8'h00, 1'b1);
        #1;
        n_checks++;
        if (out_valid[cur] !== 1'b1 || out_data[cur] !== 8'h10) begin
            n_fail++; $display("FAIL stream_last m=%0d got vld=%b data=%h exp vld=1 data=10",
                               cur, out_valid[cur], out_data[cur]);
        end
        model_edge();
        n_checks++;
        if (out_valid[cur] !== 1'b0) begin
            n_fail++; $display("FAIL stream_end m=%0d got=%b exp=0", cur, out_valid[cur]);
        end
    endtask

    task automatic test_random();
        int            sent, got, cycles;
        bit            pend, ordy, prev_stall;
        logic [DW-1:0] pd, prev_data;
        sent = 0; got = 0; cycles = 0; pend = 0; prev_stall = 0; pd = '0; prev_data = '0;
        while (got < 1000 && cycles < 20000) begin
            if (!pend && sent < 1000 && $urandom_range(0, 99) < 60) begin
                pend = 1'b1;
                pd   = DW'($urandom);
            end
            ordy = 1'($urandom_range(0, 1));
            drive(pend, pend ? pd : DW'($urandom), ordy);
            #1;
            n_checks++;
            if (out_valid[cur] !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL rand_out_valid c=%0d m=%0d got=%b exp=%b",
                                   cycles, cur, out_valid[cur], mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_checks++;
                if (out_data[cur] !== mq[0]) begin
                    n_fail++; $display("FAIL rand_out_data c=%0d m=%0d got=%h exp=%h",
                                       cycles, cur, out_data[cur], mq[0]);
                end
            end
            n_checks++;
            if (in_ready[cur] !== exp_in_ready()) begin
                n_fail++; $display("FAIL rand_in_ready c=%0d m=%0d got=%b exp=%b",
                                   cycles, cur, in_ready[cur], exp_in_ready());
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid[cur] !== 1'b1 || out_data[cur] !== prev_data) begin
                    n_fail++; $display("FAIL rand_stable c=%0d m=%0d got vld=%b data=%h exp vld=1 data=%h",
                                       cycles, cur, out_valid[cur], out_data[cur], prev_data);
                end
            end
            prev_stall = (mq.size() > 0) && !ordy;
            prev_data  = (mq.size() > 0) ? mq[0] : '0;
            model_edge();
            if (accepted) begin
                pend = 1'b0;
                sent++;
            end
            if (popped) got++;
            cycles++;
        end
        n_checks++;
        if (got != 1000 || mq.size() != 0) begin
            n_fail++; $display("FAIL rand_total m=%0d got=%0d left=%0d cycles=%0d exp=1000 left=0",
                               cur, got, mq.size(), cycles);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hCC, 1'b0);
        model_edge();
        drive(1'b0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid[cur] !== 1'b0 || out_data[cur] !== 8'h00) begin
            n_fail++; $display("FAIL async_reset m=%0d got vld=%b data=%h exp vld=0 data=00",
                               cur, out_valid[cur], out_data[cur]);
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready[cur] !== 1'b1) begin
            n_fail++; $display("FAIL async_in_ready m=%0d got=%b exp=1", cur, in_ready[cur]);
        end
        drive(1'b1, 8'hDD, 1'b1);
        model_edge();
        n_checks++;
        if (out_valid[cur] !== 1'b1 || out_data[cur] !== 8'hDD) begin
            n_fail++; $display("FAIL async_dd m=%0d got vld=%b data=%h exp vld=1 data=dd",
                               cur, out_valid[cur], out_data[cur]);
        end
        drive(1'b0, 8'h00, 1'b1);
        model_edge();
        n_checks++;
        if (out_valid[cur] !== 1'b0) begin
            n_fail++; $display("FAIL async_drain m=%0d got=%b exp=0", cur, out_valid[cur]);
        end
    endtask

    task automatic test_ready_path();
        bit exp_rdy;
        drive(1'b1, 8'hEE, 1'b0);
        model_edge();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        exp_rdy = (cur == 0) ? 1'b0 : 1'b1;
        n_checks++;
        if (in_ready[cur] !== exp_rdy) begin
            n_fail++; $display("FAIL rp_one_lo m=%0d got=%b exp=%b", cur, in_ready[cur], exp_rdy);
        end
        out_ready[cur] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[cur] !== 1'b1) begin
            n_fail++; $display("FAIL rp_one_hi m=%0d got=%b exp=1", cur, in_ready[cur]);
        end
        drive(1'b1, 8'hEF, 1'b0);
        model_edge();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (in_ready[cur] !== 1'b0) begin
            n_fail++; $display("FAIL rp_full_lo m=%0d got=%b exp=0", cur, in_ready[cur]);
        end
        out_ready[cur] = 1'b1;
        #1;
        exp_rdy = (cur == 0) ? 1'b1 : 1'b0;
        n_checks++;
        if (in_ready[cur] !== exp_rdy) begin
            n_fail++; $display("FAIL rp_full_hi m=%0d got=%b exp=%b", cur, in_ready[cur], exp_rdy);
        end
        drive(1'b0, 8'h00, 1'b1);
        for (int e = 0; e < 3; e++) model_edge();
        n_checks++;
        if (out_valid[cur] !== 1'b0 || mq.size() != 0) begin
            n_fail++; $display("FAIL rp_drain m=%0d got vld=%b left=%0d exp vld=0 left=0",
                               cur, out_valid[cur], mq.size());
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = '0;
        out_ready  = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        for (int m = 0; m < 2; m++) begin
            cur = m;
            test_reset();
            test_single();
            test_backpressure();
            test_stream();
            test_random();
            test_async_reset();
            test_ready_path();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
